// File: rtl/screen_fb_arbiter_if.sv
// Scan / CPU-write / swap / RAM bundle for screen_fb_arbiter.
// The arbiter takes the slave side; the scan engine, CPU and RAM wrapper take the master side.
interface screen_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 12
);
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_gnt;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic              frame_done;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              swap_req;
    logic              swap_pending;
    logic              front_bank;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W:0]   ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  scan_req, scan_addr, frame_done, wr_valid, wr_addr, wr_data,
               swap_req, ram_rdata,
        output scan_gnt, scan_valid, scan_data, wr_ready, swap_pending,
               front_bank, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output scan_req, scan_addr, frame_done, wr_valid, wr_addr, wr_data,
               swap_req, ram_rdata,
        input  scan_gnt, scan_valid, scan_data, wr_ready, swap_pending,
               front_bank, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/screen_fb_arbiter.sv
// Single-port framebuffer arbiter: scan reads vs. FIFO-buffered CPU writes with starvation guard.
// Define SCREEN_ARB_DBUF_EN for double buffering; otherwise everything targets bank 0.
module screen_fb_arbiter #(
    parameter int unsigned NUM_PIXELS   = 4096,
    parameter int unsigned BIT_DEPTH    = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    screen_fb_arbiter_if.slave bus
);
    localparam int unsigned AW   = $clog2(NUM_PIXELS);
    localparam int unsigned DW   = 3 * BIT_DEPTH;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;
    state_e state_q, state_d;

    logic [AW+DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  count_q, count_d;
    logic             fifo_empty, fifo_full, push, pop;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;

    logic [SW-1:0]    starve_q, starve_d;
    logic             force_wr_q, force_wr_d;

    logic             rd_bank, wr_bank, wr_inflight;

    logic             ram_en_q, ram_we_q;
    logic [AW:0]      ram_addr_q, ram_addr_d;
    logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
    logic             rd_p1_q, rd_p2_q, scan_valid_q;
    logic [DW-1:0]    scan_data_q;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CNTW'(FIFO_DEPTH));
    assign push         = bus.wr_valid && !fifo_full;
    assign pop          = (state_d == WR);
    assign {head_addr, head_data} = fifo_mem[rd_ptr_q];
    assign bus.wr_ready = !fifo_full;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNTW'(1);
        else if (pop && !push)
            count_d = count_q - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {bus.wr_addr, bus.wr_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Reset gates the selection so a held scan_req cannot be granted during reset.
    always_comb begin
        state_d = IDLE;
        if (!reset) begin
            if (force_wr_q && !fifo_empty)
                state_d = WR;
            else if (bus.scan_req)
                state_d = RD;
            else if (!fifo_empty)
                state_d = WR;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (state_d == WR || fifo_empty)
            starve_d = '0;
        else if (state_d == RD && starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
        force_wr_d = (starve_d == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            force_wr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            force_wr_q <= force_wr_d;
        end
    end

    assign wr_inflight  = (state_q == WR);
    assign bus.scan_gnt = (state_d == RD);

`ifdef SCREEN_ARB_DBUF_EN
    logic front_q, front_d, pend_q, pend_d, swap_go;

    // A RAM write issued this cycle still belongs to the old back bank, so it blocks the swap.
    assign swap_go = pend_q && bus.frame_done && fifo_empty && !wr_inflight;

    always_comb begin
        front_d = front_q ^ swap_go;
        pend_d  = swap_go ? 1'b0 : (pend_q || bus.swap_req);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            front_q <= front_d;
            pend_q  <= pend_d;
        end
    end

    assign rd_bank          = front_q;
    assign wr_bank          = ~front_q;
    assign bus.front_bank   = front_q;
    assign bus.swap_pending = pend_q;
`else
    logic unused_dbuf;
    assign unused_dbuf      = &{1'b0, bus.swap_req, bus.frame_done, wr_inflight};
    assign rd_bank          = 1'b0;
    assign wr_bank          = 1'b0;
    assign bus.front_bank   = 1'b0;
    assign bus.swap_pending = 1'b0;
`endif

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_d)
            RD: ram_addr_d = {rd_bank, bus.scan_addr};
            WR: begin
                ram_addr_d  = {wr_bank, head_addr};
                ram_wdata_d = head_data;
            end
            default: ;
        endcase
    end

    // Read return: strobe at N+1, RAM data at N+2, registered to scan_data at N+3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rd_p1_q      <= 1'b0;
            rd_p2_q      <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_data_q  <= '0;
        end else begin
            ram_en_q     <= (state_d != IDLE);
            ram_we_q     <= (state_d == WR);
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_p1_q      <= (state_d == RD);
            rd_p2_q      <= rd_p1_q;
            scan_valid_q <= rd_p2_q;
            if (rd_p2_q)
                scan_data_q <= bus.ram_rdata;
        end
    end

    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.scan_data  = scan_data_q;
endmodule

// File: doc/screen_fb_arbiter.md
SCREEN_FB_ARBITER -- requirements
Module: screen_fb_arbiter

Interface
REQ-001 The block SHALL have these parameters: NUM_PIXELS, default 4096, framebuffer pixels per bank; BIT_DEPTH, default 4, bits per colour channel (pixel word = 3*BIT_DEPTH); FIFO_DEPTH, default 4, CPU write FIFO entries (power of 2); STARVE_LIMIT, default 8, consecutive scan-only grants tolerated while writes are pending.
REQ-002 The block SHALL have one clock and one reset: reset is asynchronous and active-high, with ports named clk and reset.
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- scan_req  in  1  scan engine read request
- scan_addr  in  clog2(NUM_PIXELS)  pixel index to read
- scan_gnt  out  1  read accepted this cycle
- scan_valid  out  1  scan_data valid pulse
- scan_data  out  3*BIT_DEPTH  pixel word {R,G,B}
- frame_done  in  1  one-cycle pulse at end of scan frame
- wr_valid  in  1  CPU write offer
- wr_ready  out  1  FIFO can accept
- wr_addr  in  clog2(NUM_PIXELS)  pixel index
- wr_data  in  3*BIT_DEPTH  pixel word
- swap_req  in  1  one-cycle pulse requesting a buffer swap
- swap_pending  out  1  swap requested, not yet done
- front_bank  out  1  bank being scanned
- ram_en, ram_we  out  1 each  single-port RAM strobes
- ram_addr  out  clog2(NUM_PIXELS)+1  {bank, pixel}
- ram_wdata  out  3*BIT_DEPTH  RAM write data
- ram_rdata  in  3*BIT_DEPTH  RAM read data, 1-cycle synchronous latency

Function
REQ-004 The block SHALL accept a CPU write when wr_valid && wr_ready, pushing {wr_addr, wr_data} into the FIFO; wr_ready SHALL be !full, and the block SHALL NOT accept a push when full even if a pop occurs in the same cycle.
REQ-005 The arbiter FSM SHALL use the states IDLE, RD and WR; each cycle it SHALL select, combinationally: forced WR if force_wr is set and the FIFO is non-empty; else RD if scan_req; else WR if the FIFO is non-empty; else IDLE.
REQ-006 scan_gnt SHALL be asserted combinationally when RD is selected, and the scan engine SHALL hold scan_req and scan_addr until granted.
REQ-007 The starvation counter SHALL increment on each RD cycle while the FIFO is non-empty, clear on any WR cycle or when the FIFO is empty, and set force_wr for the next cycle when it reaches STARVE_LIMIT.
REQ-008 The RAM strobes SHALL be registered:
- selection in cycle N -> ram_en (plus ram_we for WR) in cycle N+1
- RD: ram_addr = {front_bank, scan_addr}
- WR: FIFO pops in cycle N; ram_addr = {~front_bank, fifo addr}, ram_wdata = fifo data
REQ-009 For a read granted in cycle N, the block SHALL register scan_data from ram_rdata and pulse scan_valid for one cycle in N+3 (3-cycle latency), with reads returned in grant order.
REQ-010 A swap_req pulse SHALL set swap_pending, and a swap_req while pending SHALL be ignored.
REQ-011 The swap SHALL execute on the first frame_done seen with swap_pending=1 AND the FIFO empty AND no WR in flight: front_bank toggles and swap_pending clears on the next edge.
REQ-012 On swap, if frame_done arrives while the FIFO is non-empty, the swap SHALL defer to a later frame_done.
REQ-013 If swap_req and frame_done coincide with pending=0, the block SHALL only set pending and SHALL NOT swap on that frame_done.
REQ-014 Address arithmetic SHALL be unsigned, and out-of-range pixel indices (>= NUM_PIXELS) SHALL wrap modulo the port width.

Reset
REQ-015 While reset is asserted, the block SHALL hold scan_gnt=0, scan_valid=0, scan_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, front_bank=0, swap_pending=0, starve counter=0, force_wr=0, FSM=IDLE, FIFO empty, and wr_ready=1.
REQ-016 A reset asserted mid-operation SHALL discard FIFO contents and in-flight reads, and SHALL produce no scan_valid for reads already granted.

Configuration
REQ-017 With macro SCREEN_ARB_DBUF_EN defined, the block SHALL implement double buffering per REQ-010..013.
REQ-018 With SCREEN_ARB_DBUF_EN undefined, the block SHALL operate single-bank:
- front_bank, swap_pending tied 0; ram_addr MSB always 0
- swap_req ignored; reads and writes both target bank 0

Verification
REQ-019 The bench SHALL cover these scenarios:
- reset, then 3 CPU writes to pixels 5,6,7 with data 0xF00, no scan -> 3 WR cycles, ram_addr MSB=1 (DBUF), wr_ready stays 1
- 5 writes back-to-back with FIFO_DEPTH=4, no drain (scan_req held) -> 5th write stalls with wr_ready=0 until the first pop
- scan_req held continuously with 1 queued write, STARVE_LIMIT=8 -> exactly 8 RD grants, then 1 cycle scan_gnt=0 with a WR, then RD resumes
- granted read of pixel 0x010 with ram_rdata=0x0A5 -> scan_valid pulse 3 cycles after grant with scan_data=0x0A5
- swap_req, then frame_done while 2 writes queued -> no swap; next frame_done after drain -> front_bank 0->1, swap_pending 1->0
- reset asserted 1 cycle after a read grant -> no scan_valid, FIFO empty, front_bank=0
